mips_exec_pc_unit: RTL and testbench
====================================

// Module: mips_exec_pc_unit
// PURPOSE
//  Execute-stage datapath slice of the single-cycle MIPS-I Harvard CPU.
//  - Program counter register with its +4 incrementer.
//  - Branch-target adder.
//  - Main ALU, including the branch-condition signal and the HI/LO registers.
//  Sits between the register file / instruction decode and the next-PC muxes
//  (jump, JR) of the CPU top level.
// PARAMETERS
//  RESET_VECTOR  32'hBFC0_0000  PC value loaded on reset
// PORTS
//  clk            in   1   system clock; all state updates on its rising edge
//  reset          in   1   synchronous, active-low reset
//  clk_enable     in   1   1 = state (PC, HI, LO) may update this edge
//  pc_in          in   32  next-PC value chosen by the top-level muxes
//  pc_out         out  32  current PC (drives instr_address)
//  pc_plus4       out  32  pc_out + 4
//  branch_addr    out  32  pc_plus4 + (sext(immediate) << 2)
//  opcode         in   6   instr[31:26]
//  functcode      in   6   instr[5:0]
//  shamt          in   5   instr[10:6]
//  rt_sel         in   5   instr[20:16]; REGIMM sub-op select
//  immediate      in   16  instr[15:0]
//  rs_content     in   32  rs register value
//  rt_content     in   32  rt register value
//  alu_result     out  32  combinational result / memory address
//  sig_branch     out  1   1 = conditional branch taken
//  hi, lo         out  32  HI/LO register contents
// BEHAVIOUR
//  Reset (reset==0 at clk edge; overrides clk_enable):
//  - pc_out <= RESET_VECTOR; hi <= 0; lo <= 0.
//  State updates:
//  - PC: with reset==1 and clk_enable==1, pc_out <= pc_in.
//    With clk_enable==0, PC, HI and LO all hold.
//  - All other outputs are combinational, with zero latency.
//  Adders (all arithmetic mod 2^32, wraps, no overflow traps):
//  - pc_plus4 = pc_out + 4.
//  - branch_addr = pc_plus4 + {{14{imm[15]}}, imm, 2'b00}.
//  R-type (opcode 0), selected by functcode:
//  - Shifts: SLL 00 / SRL 02 / SRA 03 shift rt by shamt;
//    SLLV 04 / SRLV 06 / SRAV 07 shift rt by rs[4:0].
//  - Add/subtract: ADDU 21 = rs+rt; SUBU 23 = rs-rt.
//  - Logic: AND 24, OR 25, XOR 26.
//  - Compare: SLT 2A (signed), SLTU 2B (unsigned); result is 1 or 0.
//  - HI/LO moves: MFHI 10 returns hi; MFLO 12 returns lo.
//  - JR 08 / JALR 09: alu_result = pc_out + 8 (link value).
//  - HI/LO writes (clocked, clk_enable==1):
//    - MTHI 11: hi <= rs. MTLO 13: lo <= rs.
//    - MULT 18 (signed) / MULTU 19: {hi,lo} <= rs*rt, full 64-bit product.
//    - DIV 1A (signed, truncating) / DIVU 1B: lo <= quotient, hi <= remainder.
//    - Divide by rt==0: hi and lo hold.
//    - Signed 32'h8000_0000 / -1: lo = 32'h8000_0000, hi = 0.
//  I-type, selected by opcode:
//  - Immediate ops: ADDIU 09 = rs + sext(imm); SLTI 0A; SLTIU 0B (compares
//    against sext(imm), unsigned compare).
//  - ANDI 0C / ORI 0D / XORI 0E use zext(imm); LUI 0F = {imm, 16'h0}.
//  - Loads/stores (opcodes 20-26, 28, 29, 2B): alu_result = rs + sext(imm).
//  - JAL 03: alu_result = pc_out + 8.
//  Branches (sig_branch; alu_result = 0):
//  - BEQ 04: rs==rt. BNE 05: rs!=rt.
//  - BLEZ 06: rs<=0 signed. BGTZ 07: rs>0 signed.
//  - REGIMM 01, selected by rt_sel:
//    - BLTZ 00 / BLTZAL 10: rs<0.
//    - BGEZ 01 / BGEZAL 11: rs>=0.
//    - BLTZAL/BGEZAL: alu_result = pc_out + 8.
//  Defaults:
//  - sig_branch = 0 for every non-branch opcode.
//  - Any unlisted opcode or funct gives alu_result = 0, sig_branch = 0,
//    and no HI/LO write.
// CONFIGURATION
//  ALU_MULDIV_EN:
//  - Defined: HI/LO registers and MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO are
//    implemented as above.
//  - Undefined: no HI/LO state; hi = lo = 0 constant; the four multiply/divide
//    ops and MTHI/MTLO have no effect; MFHI/MFLO return 0.
// TESTING
//  1. Reset: reset=0 for one edge -> pc_out=BFC0_0000, pc_plus4=BFC0_0004,
//     hi=lo=0. Then reset=1, clk_enable=0, pc_in=0x100 -> pc_out holds.
//  2. PC: clk_enable=1, pc_out=0x100, imm=16'hFFFF -> branch_addr=0x100;
//     pc_in=0x200 -> next edge pc_out=0x200.
//  3. Arithmetic: ADDU FFFF_FFFF+1 -> 0. SRA rt=8000_0000, shamt=4 ->
//     F800_0000. SLTI rs=-1, imm=0 -> 1. SLTIU rs=1, imm=FFFF -> 1.
//     LUI imm=1234 -> 1234_0000.
//  4. Branches: BEQ 5,5 -> sig_branch=1. BGTZ rs=0 -> 0.
//     REGIMM rt_sel=01, rs=0 -> 1 (BGEZ).
//  5. MULT rs=-2, rt=3 -> hi=FFFF_FFFF, lo=FFFF_FFFA. DIVU 7/2 -> lo=3, hi=1.
//     DIV by 0 -> hi/lo unchanged. MFLO -> alu_result=lo.
//  6. Without ALU_MULDIV_EN: MULT rs=2, rt=3 -> hi=lo=0; MFLO -> 0.

Source files
------------

// File: rtl/mips_exec_pc_unit.sv
// mips_exec_pc_unit: execute-stage PC register, branch adder and ALU; HI/LO multiply/divide is built only when ALU_MULDIV_EN is defined
module mips_exec_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_addr,
  input  logic [5:0]  opcode,
  input  logic [5:0]  functcode,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rt_sel,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  output logic [31:0] alu_result,
  output logic        sig_branch,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic [31:0] r_pc;
  logic [31:0] w_link;
  logic [31:0] w_simm;
  logic [31:0] w_zimm;
  logic [31:0] w_alu;
  logic        w_branch;
  logic        w_rs_neg;
  logic        w_rs_zero;
  assign pc_out      = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign branch_addr = pc_plus4 + {{14{immediate[15]}}, immediate, 2'b00};
  assign w_link      = r_pc + 32'd8;
  assign w_simm      = {{16{immediate[15]}}, immediate};
  assign w_zimm      = {16'h0, immediate};
  assign w_rs_neg    = rs_content[31];
  assign w_rs_zero   = rs_content == 32'h0;
  assign alu_result  = w_alu;
  assign sig_branch  = w_branch;
  always_ff @(posedge clk) begin
    if (!reset)
      r_pc <= RESET_VECTOR;
    else if (clk_enable)
      r_pc <= pc_in;
  end
  always_comb begin
    w_alu    = '0;
    w_branch = 1'b0;
    case (opcode)
      6'h00: begin
        case (functcode)
          6'h00:        w_alu = rt_content << shamt;
          6'h02:        w_alu = rt_content >> shamt;
          6'h03:        w_alu = $signed(rt_content) >>> shamt;
          6'h04:        w_alu = rt_content << rs_content[4:0];
          6'h06:        w_alu = rt_content >> rs_content[4:0];
          6'h07:        w_alu = $signed(rt_content) >>> rs_content[4:0];
          6'h08, 6'h09: w_alu = w_link;
          6'h10:        w_alu = hi;
          6'h12:        w_alu = lo;
          6'h21:        w_alu = rs_content + rt_content;
          6'h23:        w_alu = rs_content - rt_content;
          6'h24:        w_alu = rs_content & rt_content;
          6'h25:        w_alu = rs_content | rt_content;
          6'h26:        w_alu = rs_content ^ rt_content;
          6'h2A:        w_alu = {31'b0, $signed(rs_content) < $signed(rt_content)};
          6'h2B:        w_alu = {31'b0, rs_content < rt_content};
          default:      w_alu = '0;
        endcase
      end
      6'h01: begin
        w_branch = (rt_sel == 5'h00 || rt_sel == 5'h10) ? w_rs_neg :
                   (rt_sel == 5'h01 || rt_sel == 5'h11) ? !w_rs_neg : 1'b0;
        w_alu    = (rt_sel == 5'h10 || rt_sel == 5'h11) ? w_link : '0;
      end
      6'h03: w_alu    = w_link;
      6'h04: w_branch = rs_content == rt_content;
      6'h05: w_branch = rs_content != rt_content;
      6'h06: w_branch = w_rs_neg || w_rs_zero;
      6'h07: w_branch = !w_rs_neg && !w_rs_zero;
      6'h09: w_alu    = rs_content + w_simm;
      6'h0A: w_alu    = {31'b0, $signed(rs_content) < $signed(w_simm)};
      6'h0B: w_alu    = {31'b0, rs_content < w_simm};
      6'h0C: w_alu    = rs_content & w_zimm;
      6'h0D: w_alu    = rs_content | w_zimm;
      6'h0E: w_alu    = rs_content ^ w_zimm;
      6'h0F: w_alu    = {immediate, 16'h0};
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2B:
             w_alu    = rs_content + w_simm;
      default: w_alu  = '0;
    endcase
  end
`ifdef ALU_MULDIV_EN
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] w_mul_s;
  logic [63:0] w_mul_u;
  logic [31:0] w_div_den;
  logic [31:0] w_divu_den;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;
  logic [31:0] w_divu_q;
  logic [31:0] w_divu_r;
  logic        w_rt_zero;
  assign w_rt_zero  = rt_content == 32'h0;
  assign w_mul_s    = {{32{rs_content[31]}}, rs_content} * {{32{rt_content[31]}}, rt_content};
  assign w_mul_u    = {32'h0, rs_content} * {32'h0, rt_content};
  // Dividing MIN_INT by 1 instead of -1 yields exactly the required 8000_0000 / 0
  assign w_div_den  = (w_rt_zero || (rs_content == 32'h8000_0000 && rt_content == 32'hFFFF_FFFF)) ? 32'd1 : rt_content;
  assign w_divu_den = w_rt_zero ? 32'd1 : rt_content;
  assign w_div_q    = $signed(rs_content) / $signed(w_div_den);
  assign w_div_r    = $signed(rs_content) % $signed(w_div_den);
  assign w_divu_q   = rs_content / w_divu_den;
  assign w_divu_r   = rs_content % w_divu_den;
  assign hi         = r_hi;
  assign lo         = r_lo;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (clk_enable && opcode == 6'h00) begin
      case (functcode)
        6'h11: r_hi <= rs_content;
        6'h13: r_lo <= rs_content;
        6'h18: {r_hi, r_lo} <= w_mul_s;
        6'h19: {r_hi, r_lo} <= w_mul_u;
        6'h1A: if (!w_rt_zero) begin
          r_hi <= w_div_r;
          r_lo <= w_div_q;
        end
        6'h1B: if (!w_rt_zero) begin
          r_hi <= w_divu_r;
          r_lo <= w_divu_q;
        end
        default: ;
      endcase
    end
  end
`else
  assign hi = '0;
  assign lo = '0;
`endif
endmodule

// File: tb/tb_mips_exec_pc_unit.sv
// tb_mips_exec_pc_unit: directed and randomized checks of the execute-stage PC/ALU against a behavioural model
module tb_mips_exec_pc_unit;
  localparam logic [31:0] RV = 32'hBFC0_0000;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_out, pc_plus4, branch_addr, alu_result, hi, lo;
  logic [5:0]  opcode = '0, functcode = '0;
  logic [4:0]  shamt = '0, rt_sel = '0;
  logic [15:0] immediate = '0;
  logic [31:0] rs_content = '0, rt_content = '0;
  logic        sig_branch;
  logic [31:0] m_pc, m_hi, m_lo;
  int tests = 0;
  int fails = 0;

  mips_exec_pc_unit dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .pc_in(pc_in),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .branch_addr(branch_addr),
    .opcode(opcode), .functcode(functcode), .shamt(shamt), .rt_sel(rt_sel),
    .immediate(immediate), .rs_content(rs_content), .rt_content(rt_content),
    .alu_result(alu_result), .sig_branch(sig_branch), .hi(hi), .lo(lo)
  );

  initial forever #5 clk = ~clk;

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [4:0] rsel, input logic [15:0] im,
                       input logic [31:0] a, input logic [31:0] b);
    opcode = op; functcode = fn; shamt = sh; rt_sel = rsel; immediate = im;
    rs_content = a; rt_content = b;
    #1;
  endtask

  // Model state advances from the inputs present just before the edge
  task automatic tick();
    longint q, r;
    logic [63:0] p;
    int s, t;
    s = rs_content;
    t = rt_content;
    if (!reset) begin
      m_pc = RV; m_hi = '0; m_lo = '0;
    end else if (clk_enable) begin
      m_pc = pc_in;
      if (MD && opcode == 6'h00) begin
        case (functcode)
          6'h11: m_hi = rs_content;
          6'h13: m_lo = rs_content;
          6'h18: begin p = 64'(longint'(s) * longint'(t)); m_hi = p[63:32]; m_lo = p[31:0]; end
          6'h19: begin p = 64'(longint'({32'h0, rs_content}) * longint'({32'h0, rt_content})); m_hi = p[63:32]; m_lo = p[31:0]; end
          6'h1A: if (t != 0) begin
            q = longint'(s) / longint'(t);
            r = longint'(s) % longint'(t);
            m_lo = q[31:0]; m_hi = r[31:0];
          end
          6'h1B: if (rt_content != 0) begin
            m_lo = rt_content == 0 ? 32'h0 : rs_content / rt_content;
            m_hi = rs_content % rt_content;
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_alu();
    int s, t, si;
    s = rs_content; t = rt_content; si = $signed(immediate);
    case (opcode)
      6'h00: case (functcode)
        6'h00: return rt_content << shamt;
        6'h02: return rt_content >> shamt;
        6'h03: return 32'(t >>> shamt);
        6'h04: return rt_content << rs_content[4:0];
        6'h06: return rt_content >> rs_content[4:0];
        6'h07: return 32'(t >>> rs_content[4:0]);
        6'h08, 6'h09: return m_pc + 32'd8;
        6'h10: return m_hi;
        6'h12: return m_lo;
        6'h21: return 32'(s + t);
        6'h23: return 32'(s - t);
        6'h24: return rs_content & rt_content;
        6'h25: return rs_content | rt_content;
        6'h26: return rs_content ^ rt_content;
        6'h2A: return (s < t) ? 32'd1 : 32'd0;
        6'h2B: return (rs_content < rt_content) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
      6'h01: return (rt_sel == 5'h10 || rt_sel == 5'h11) ? m_pc + 32'd8 : 32'd0;
      6'h03: return m_pc + 32'd8;
      6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2B:
             return 32'(s + si);
      6'h0A: return (s < si) ? 32'd1 : 32'd0;
      6'h0B: return (rs_content < 32'(si)) ? 32'd1 : 32'd0;
      6'h0C: return rs_content & 32'(immediate);
      6'h0D: return rs_content | 32'(immediate);
      6'h0E: return rs_content ^ 32'(immediate);
      6'h0F: return 32'(immediate) * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_br();
    int s;
    s = rs_content;
    case (opcode)
      6'h01: return (rt_sel == 5'h00 || rt_sel == 5'h10) ? (s < 0) :
                    (rt_sel == 5'h01 || rt_sel == 5'h11) ? (s >= 0) : 1'b0;
      6'h04: return rs_content == rt_content;
      6'h05: return rs_content != rt_content;
      6'h06: return s <= 0;
      6'h07: return s > 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    drive(6'h00, 6'h00, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    reset = 1'b0; clk_enable = 1'b1; pc_in = 32'h1234;
    tick();
    tests++; if (pc_out !== RV) begin fails++; $display("FAIL reset_pc got=%h exp=%h", pc_out, RV); end
    tests++; if (pc_plus4 !== 32'hBFC0_0004) begin fails++; $display("FAIL reset_pc4 got=%h exp=%h", pc_plus4, 32'hBFC0_0004); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got=%h exp=0", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got=%h exp=0", lo); end
    reset = 1'b1; clk_enable = 1'b0; pc_in = 32'h100;
    tick();
    tests++; if (pc_out !== RV) begin fails++; $display("FAIL hold_pc got=%h exp=%h", pc_out, RV); end
  endtask

  task automatic test_pc();
    clk_enable = 1'b1;
    tick();
    drive(6'h00, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h0, 32'h0);
    tests++; if (pc_out !== 32'h100) begin fails++; $display("FAIL pc_load got=%h exp=100", pc_out); end
    tests++; if (branch_addr !== 32'h100) begin fails++; $display("FAIL branch_neg got=%h exp=100", branch_addr); end
    drive(6'h04, 6'h00, 5'd0, 5'd0, 16'h7FFF, 32'h0, 32'h0);
    tests++; if (branch_addr !== 32'h0002_0100) begin fails++; $display("FAIL branch_pos got=%h exp=20100", branch_addr); end
    pc_in = 32'h200;
    tick();
    tests++; if (pc_out !== 32'h200) begin fails++; $display("FAIL pc_next got=%h exp=200", pc_out); end
    tests++; if (pc_plus4 !== 32'h204) begin fails++; $display("FAIL pc_plus4 got=%h exp=204", pc_plus4); end
  endtask

  task automatic test_arith();
    clk_enable = 1'b0;
    drive(6'h00, 6'h21, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'h1);
    tests++; if (alu_result !== 32'h0) begin fails++; $display("FAIL addu_wrap got=%h exp=0", alu_result); end
    tests++; if (sig_branch !== 1'b0) begin fails++; $display("FAIL addu_nobr got=%b exp=0", sig_branch); end
    drive(6'h00, 6'h03, 5'd4, 5'd0, 16'h0, 32'h0, 32'h8000_0000);
    tests++; if (alu_result !== 32'hF800_0000) begin fails++; $display("FAIL sra got=%h exp=F8000000", alu_result); end
    drive(6'h0A, 6'h00, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'h0);
    tests++; if (alu_result !== 32'h1) begin fails++; $display("FAIL slti got=%h exp=1", alu_result); end
    drive(6'h0B, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h1, 32'h0);
    tests++; if (alu_result !== 32'h1) begin fails++; $display("FAIL sltiu got=%h exp=1", alu_result); end
    drive(6'h0F, 6'h00, 5'd0, 5'd0, 16'h1234, 32'hDEAD_BEEF, 32'h0);
    tests++; if (alu_result !== 32'h1234_0000) begin fails++; $display("FAIL lui got=%h exp=12340000", alu_result); end
    drive(6'h03, 6'h00, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    tests++; if (alu_result !== 32'h208) begin fails++; $display("FAIL jal_link got=%h exp=208", alu_result); end
    drive(6'h3F, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h5, 32'h5);
    tests++; if (alu_result !== 32'h0) begin fails++; $display("FAIL bad_op got=%h exp=0", alu_result); end
  endtask

  task automatic test_branches();
    drive(6'h04, 6'h00, 5'd0, 5'd0, 16'h0, 32'h5, 32'h5);
    tests++; if (sig_branch !== 1'b1) begin fails++; $display("FAIL beq got=%b exp=1", sig_branch); end
    tests++; if (alu_result !== 32'h0) begin fails++; $display("FAIL beq_alu got=%h exp=0", alu_result); end
    drive(6'h07, 6'h00, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    tests++; if (sig_branch !== 1'b0) begin fails++; $display("FAIL bgtz_zero got=%b exp=0", sig_branch); end
    drive(6'h01, 6'h00, 5'd0, 5'h01, 16'h0, 32'h0, 32'h0);
    tests++; if (sig_branch !== 1'b1) begin fails++; $display("FAIL bgez_zero got=%b exp=1", sig_branch); end
    drive(6'h01, 6'h00, 5'd0, 5'h10, 16'h0, 32'hFFFF_FFFF, 32'h0);
    tests++; if (sig_branch !== 1'b1) begin fails++; $display("FAIL bltzal got=%b exp=1", sig_branch); end
    tests++; if (alu_result !== 32'h208) begin fails++; $display("FAIL bltzal_link got=%h exp=208", alu_result); end
  endtask

  task automatic test_muldiv();
    clk_enable = 1'b1; pc_in = 32'h200;
    drive(6'h00, 6'h18, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFE, 32'h3);
    tick();
    tests++; if (hi !== (MD ? 32'hFFFF_FFFF : 32'h0)) begin fails++; $display("FAIL mult_hi got=%h exp=%h", hi, MD ? 32'hFFFF_FFFF : 32'h0); end
    tests++; if (lo !== (MD ? 32'hFFFF_FFFA : 32'h0)) begin fails++; $display("FAIL mult_lo got=%h exp=%h", lo, MD ? 32'hFFFF_FFFA : 32'h0); end
    drive(6'h00, 6'h1B, 5'd0, 5'd0, 16'h0, 32'h7, 32'h2);
    tick();
    tests++; if (lo !== (MD ? 32'h3 : 32'h0)) begin fails++; $display("FAIL divu_lo got=%h exp=%h", lo, MD ? 32'h3 : 32'h0); end
    tests++; if (hi !== (MD ? 32'h1 : 32'h0)) begin fails++; $display("FAIL divu_hi got=%h exp=%h", hi, MD ? 32'h1 : 32'h0); end
    drive(6'h00, 6'h1A, 5'd0, 5'd0, 16'h0, 32'h9, 32'h0);
    tick();
    tests++; if (lo !== (MD ? 32'h3 : 32'h0) || hi !== (MD ? 32'h1 : 32'h0)) begin fails++; $display("FAIL div0_hold got=%h/%h exp=%h/%h", hi, lo, MD ? 32'h1 : 32'h0, MD ? 32'h3 : 32'h0); end
    drive(6'h00, 6'h12, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    tests++; if (alu_result !== (MD ? 32'h3 : 32'h0)) begin fails++; $display("FAIL mflo got=%h exp=%h", alu_result, MD ? 32'h3 : 32'h0); end
    clk_enable = 1'b0;
    drive(6'h00, 6'h11, 5'd0, 5'd0, 16'h0, 32'hABCD, 32'h0);
    tick();
    tests++; if (hi !== (MD ? 32'h1 : 32'h0)) begin fails++; $display("FAIL mthi_gated got=%h exp=%h", hi, MD ? 32'h1 : 32'h0); end
    clk_enable = 1'b1;
    drive(6'h00, 6'h1A, 5'd0, 5'd0, 16'h0, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    tests++; if (lo !== (MD ? 32'h8000_0000 : 32'h0) || hi !== 32'h0) begin fails++; $display("FAIL div_ovf got=%h/%h exp=0/%h", hi, lo, MD ? 32'h8000_0000 : 32'h0); end
    drive(6'h00, 6'h1A, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFF9, 32'h2);
    tick();
    tests++; if (lo !== (MD ? 32'hFFFF_FFFD : 32'h0) || hi !== (MD ? 32'hFFFF_FFFF : 32'h0)) begin fails++; $display("FAIL div_neg got=%h/%h exp=%h/%h", hi, lo, MD ? 32'hFFFF_FFFF : 32'h0, MD ? 32'hFFFF_FFFD : 32'h0); end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [5:0] ops[$] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                           6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B, 6'h3F};
    logic [5:0] fns[$] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13,
                           6'h18, 6'h19, 6'h1A, 6'h1B, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h01, 6'h3F};
    logic [4:0] rsels[$] = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h02};
    logic [31:0] exp_ba;
    int off;
    for (int i = 0; i < 500; i++) begin
      drive(ops[$urandom_range(0, ops.size() - 1)], fns[$urandom_range(0, fns.size() - 1)],
            5'($urandom), rsels[$urandom_range(0, rsels.size() - 1)], 16'($urandom), pick_val(), pick_val());
      off = $signed(immediate);
      exp_ba = m_pc + 32'd4 + 32'(off * 4);
      tests++; if (alu_result !== m_alu()) begin fails++; $display("FAIL rnd_alu op=%h fn=%h got=%h exp=%h", opcode, functcode, alu_result, m_alu()); end
      tests++; if (sig_branch !== m_br()) begin fails++; $display("FAIL rnd_br op=%h got=%b exp=%b", opcode, sig_branch, m_br()); end
      tests++; if (pc_out !== m_pc || pc_plus4 !== m_pc + 32'd4) begin fails++; $display("FAIL rnd_pc got=%h/%h exp=%h", pc_out, pc_plus4, m_pc); end
      tests++; if (branch_addr !== exp_ba) begin fails++; $display("FAIL rnd_baddr got=%h exp=%h", branch_addr, exp_ba); end
      tests++; if (hi !== m_hi || lo !== m_lo) begin fails++; $display("FAIL rnd_hilo got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo); end
      pc_in = $urandom & 32'hFFFF_FFFC;
      clk_enable = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 63) != 0;
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    m_pc = RV; m_hi = '0; m_lo = '0;
    test_reset();
    test_pc();
    test_arith();
    test_branches();
    test_muldiv();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
